// File: rtl/uart_pkg.sv
// Shared UART definitions: default word width, default baud divisor, and the
// transmitter state type.
package uart_pkg;

  localparam int BITS_PER_WORD    = 8;
  localparam int CLOCKS_PER_PULSE = 2604;  // 50 MHz / 19200 baud

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/uart_tx_words_if.sv
// Parallel valid/ready bus feeding the word-serialising UART transmitter.
interface uart_tx_words_if #(
  parameter int W_BUS = 16
) ();

  logic             s_valid;
  logic             s_ready;
  logic [W_BUS-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: a one-cycle tick every CLOCKS_PER_PULSE cycles while en is
// high; the count is held at zero while disabled, so each enable rise restarts it.
module uart_baud_tick #(
  parameter int CLOCKS_PER_PULSE = uart_pkg::CLOCKS_PER_PULSE
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  // A divisor of 1 still needs a one-bit counter that simply stays at zero.
  localparam int CW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_PULSE - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign tick = en && (cnt_reg == LAST);

endmodule

// File: rtl/uart_tx_words.sv
// Serialises a W_BUS-bit bus as N_WORDS back-to-back UART words, word 0 first.
// Define UART_TX_PARITY_EN to replace the first trailing bit with even parity.
module uart_tx_words #(
  parameter int CLOCKS_PER_PULSE = uart_pkg::CLOCKS_PER_PULSE,
  parameter int BITS_PER_WORD    = uart_pkg::BITS_PER_WORD,
  parameter int PACKET_SIZE      = BITS_PER_WORD + 5,
  parameter int W_BUS            = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_words_if.slave  s_bus,
  output logic            tx,
  output logic            busy
);

  import uart_pkg::state_t;
  import uart_pkg::IDLE;
  import uart_pkg::SEND;

  localparam int N_WORDS = W_BUS / BITS_PER_WORD;
  localparam int BCW     = $clog2(PACKET_SIZE);
  localparam int WCW     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [BCW-1:0] LAST_BIT  = BCW'(PACKET_SIZE - 1);
  localparam logic [BCW-1:0] DATA_END  = BCW'(BITS_PER_WORD);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(N_WORDS - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic [BCW-1:0] PAR_BIT   = BCW'(BITS_PER_WORD + 1);
`endif

  state_t                   state_reg, state_next;
  logic [W_BUS-1:0]         frame_reg, frame_next, frame_shifted;
  logic [BCW-1:0]           bit_cnt_reg, bit_cnt_next;
  logic [WCW-1:0]           word_cnt_reg, word_cnt_next;
  logic                     tx_reg, tx_next;
  logic                     tick;
  logic [BITS_PER_WORD-1:0] cur_word;

  // Value of bit position idx within one word frame (0 = start bit).
  function automatic logic frame_bit(input logic [BCW-1:0] idx,
                                     input logic [BITS_PER_WORD-1:0] w);
    logic [BITS_PER_WORD-1:0] sh;
    sh = w >> (idx - BCW'(1));
    if (idx == '0) return 1'b0;
    if (idx <= DATA_END) return sh[0];
`ifdef UART_TX_PARITY_EN
    if (idx == PAR_BIT) return ^w;
`endif
    return 1'b1;
  endfunction

  // Word-granular shift: the word in flight always sits in the low slot.
  genvar gi;
  for (gi = 0; gi < N_WORDS; gi++) begin : g_shift
    if (gi < N_WORDS - 1) begin : g_mid
      assign frame_shifted[gi*BITS_PER_WORD +: BITS_PER_WORD] =
        frame_reg[(gi+1)*BITS_PER_WORD +: BITS_PER_WORD];
    end else begin : g_top
      assign frame_shifted[gi*BITS_PER_WORD +: BITS_PER_WORD] = '0;
    end
  end

  assign cur_word = frame_reg[BITS_PER_WORD-1:0];

  uart_baud_tick #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .en  (state_reg == SEND),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      frame_reg    <= '0;
      bit_cnt_reg  <= '0;
      word_cnt_reg <= '0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      frame_reg    <= frame_next;
      bit_cnt_reg  <= bit_cnt_next;
      word_cnt_reg <= word_cnt_next;
      tx_reg       <= tx_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    frame_next    = frame_reg;
    bit_cnt_next  = bit_cnt_reg;
    word_cnt_next = word_cnt_reg;
    tx_next       = tx_reg;
    case (state_reg)
      IDLE: begin
        if (s_bus.s_valid) begin
          state_next    = SEND;
          frame_next    = s_bus.s_data;
          bit_cnt_next  = '0;
          word_cnt_next = '0;
          tx_next       = 1'b0;
        end
      end
      SEND: begin
        if (tick) begin
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next = '0;
            if (word_cnt_reg == LAST_WORD) begin
              state_next    = IDLE;
              word_cnt_next = '0;
              tx_next       = 1'b1;
            end else begin
              word_cnt_next = word_cnt_reg + WCW'(1);
              frame_next    = frame_shifted;
              tx_next       = 1'b0;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + BCW'(1);
            tx_next      = frame_bit(bit_cnt_reg + BCW'(1), cur_word);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Held low through reset so nothing is accepted until the cycle after release.
  assign s_bus.s_ready = (state_reg == IDLE) && !rst;
  assign busy          = (state_reg == SEND);
  assign tx            = tx_reg;

endmodule

// File: doc/uart_tx_words.md
UART_TX_WORDS -- requirements
Module: uart_tx_words

Interface
REQ-001 SHALL have parameter CLOCKS_PER_PULSE, default 2604, clock cycles per UART bit (50 MHz / 19200).
REQ-002 SHALL have parameter BITS_PER_WORD, default 8, data bits per UART word.
REQ-003 SHALL have parameter PACKET_SIZE, default BITS_PER_WORD+5, total bits per word frame: start + data + trailing ones.
REQ-004 SHALL have parameter W_BUS, default 16, parallel input width; W_BUS % BITS_PER_WORD == 0; N_WORDS = W_BUS/BITS_PER_WORD.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 s_valid  input  1  parallel bus valid.
REQ-009 s_ready  output  1  block can accept a bus.
REQ-010 s_data  input  W_BUS  bus to serialize; word 0 = s_data[BITS_PER_WORD-1:0].
REQ-011 tx  output  1  UART serial line, idle high.
REQ-012 busy  output  1  frame transmission in progress.

Function
REQ-013 SHALL implement states IDLE and SEND only.
REQ-014 IDLE: tx=1, s_ready=1, busy=0.
REQ-015 Handshake: s_valid && s_ready on an edge SHALL capture s_data and enter SEND; s_data is ignored at all other times.
REQ-016 tx SHALL drive the first start bit (0) in the cycle immediately after the handshake edge: 1-cycle latency.
REQ-017 Each word frame: start bit 0; data bits LSB first; then PACKET_SIZE-BITS_PER_WORD-1 ones.
REQ-018 Every bit SHALL hold for exactly CLOCKS_PER_PULSE cycles.
REQ-019 Words 0..N_WORDS-1 SHALL be sent in ascending order, back-to-back with no idle gap.
REQ-020 s_ready SHALL be 0 throughout SEND; s_valid held during SEND SHALL be ignored and not queued.
REQ-021 After the last trailing bit of word N_WORDS-1 completes, SHALL return to IDLE; s_ready=1 on that cycle.
REQ-022 A new handshake in the first IDLE cycle SHALL start the next frame immediately, with a one-cycle tx=1 gap at minimum.
REQ-023 Counters: pulse counter width $clog2(CLOCKS_PER_PULSE); bit counter wraps at PACKET_SIZE; word counter wraps at N_WORDS; no counter SHALL overflow or reach an undefined value.
REQ-024 CLOCKS_PER_PULSE=1 SHALL be supported: one bit per cycle.

Reset
REQ-025 rst=1 SHALL force IDLE, tx=1, busy=0, s_ready=0 during reset and 1 on the first cycle after reset is released, and SHALL clear all counters.
REQ-026 rst asserted mid-frame SHALL abort the frame on the next edge: tx=1, no partial word resumed.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: the first trailing bit SHALL be even parity (XOR of the data bits); the remaining trailing bits stay 1; PACKET_SIZE >= BITS_PER_WORD+3 is required.
REQ-028 Macro UART_TX_PARITY_EN undefined: all trailing bits SHALL be 1; PACKET_SIZE >= BITS_PER_WORD+2 is required.

Structure
REQ-029 Shared package uart_pkg SHALL hold BITS_PER_WORD, the default CLOCKS_PER_PULSE, and the state enum type.
REQ-030 Sub-module uart_baud_tick SHALL produce a one-cycle tick every CLOCKS_PER_PULSE cycles while enabled, restarting on enable rise.
REQ-031 The frame SHALL be stored in a shift register of N_WORDS*BITS_PER_WORD bits or equivalent.

Verification (CLOCKS_PER_PULSE=4, W_BUS=16, PACKET_SIZE=13 unless stated)
REQ-032 s_data=16'hA53C, single handshake -> tx sequence word0 0,0,0,1,1,1,1,0,0 then 4 ones; word1 0,1,0,1,0,0,1,0,1 then 4 ones; each bit held 4 cycles; total 104 cycles; s_ready back to 1 at cycle 105.
REQ-033 s_valid held high with changing s_data during SEND -> only the captured value is transmitted; exactly one frame is sent per handshake.
REQ-034 rst pulsed at cycle 30 of a frame -> tx=1 and busy=0 from the next cycle; the next handshake with 16'h00FF sends a clean full frame.
REQ-035 Back-to-back handshakes of 16'h1234 and 16'h5678 -> two complete frames, at least 1 idle cycle between them, both bit-exact.
REQ-036 UART_TX_PARITY_EN defined, s_data=16'h0701 -> the bit after the data of word0 is 1 and of word1 is 1; with 16'h0300 both are 0.
REQ-037 Random 200 buses checked against a reference UART receiver sampling at mid-bit -> all match; CLOCKS_PER_PULSE=1 variant also passes.
